// File: rtl/ps2_tx.sv
`default_nettype none
// ============================================================================
// Module   : ps2_tx
// Brief    : PS/2 host-to-device transmitter: inhibit, start, 8 data bits LSB
//            first, odd parity, stop, then device acknowledge and bus-idle wait.
// Revision : 1.0  initial release
// ============================================================================
module ps2_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int FILTER         = 8
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    input  logic       i_start,
    input  logic [7:0] i_data,
    output logic       o_ps2_clk_oe,
    output logic       o_ps2_data_oe,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_err
);

    localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int FLT_W = (FILTER > 1) ? $clog2(FILTER) : 1;

    localparam logic [INH_W-1:0] c_inh_last = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [INH_W-1:0] c_inh_pre  =
        INH_W'((INHIBIT_CYCLES > 1) ? (INHIBIT_CYCLES - 2) : 0);
    localparam logic [TO_W-1:0]  c_to_last  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [FLT_W-1:0] c_flt_last = FLT_W'(FILTER - 1);
    localparam logic [3:0]       c_bit_stop = 4'd9;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_INHIBIT   = 3'd1,
        S_START     = 3'd2,
        S_BITS      = 3'd3,
        S_ACK       = 3'd4,
        S_WAIT_IDLE = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         clk_sync_q;
    logic [1:0]         dat_sync_q;
    logic               filt_q, filt_d;
    logic [FLT_W-1:0]   flt_cnt_q, flt_cnt_d;
    logic [INH_W-1:0]   inh_cnt_q, inh_cnt_d;
    logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
    logic [3:0]         bit_cnt_q, bit_cnt_d;
    logic [9:0]         frame_q, frame_d;
    logic               clk_oe_q, clk_oe_d;
    logic               data_oe_q, data_oe_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               fall;
    logic               timeout;

    // Synchronizers idle high so a reset never fabricates a falling edge.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            filt_q     <= 1'b1;
            flt_cnt_q  <= '0;
        end else begin
            clk_sync_q <= {clk_sync_q[0], i_ps2_clk};
            dat_sync_q <= {dat_sync_q[0], i_ps2_data};
            filt_q     <= filt_d;
            flt_cnt_q  <= flt_cnt_d;
        end
    end

    always_comb begin
        filt_d    = filt_q;
        flt_cnt_d = '0;
        if (clk_sync_q[1] != filt_q) begin
            if (flt_cnt_q == c_flt_last) begin
                filt_d = clk_sync_q[1];
            end else begin
                flt_cnt_d = flt_cnt_q + FLT_W'(1);
            end
        end
    end

    assign fall    = filt_q & ~filt_d;
    assign timeout = (to_cnt_q == c_to_last);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            inh_cnt_q <= '0;
            to_cnt_q  <= '0;
            bit_cnt_q <= '0;
            frame_q   <= '0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            inh_cnt_q <= inh_cnt_d;
            to_cnt_q  <= to_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            frame_q   <= frame_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        inh_cnt_d = inh_cnt_q;
        to_cnt_d  = fall ? '0 : (to_cnt_q + TO_W'(1));
        bit_cnt_d = bit_cnt_q;
        frame_d   = frame_q;
        clk_oe_d  = 1'b0;
        data_oe_d = data_oe_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                data_oe_d = 1'b0;
                to_cnt_d  = '0;
                if (i_start) begin
                    frame_d   = {1'b1, ~^i_data, i_data};
                    inh_cnt_d = '0;
                    busy_d    = 1'b1;
                    clk_oe_d  = 1'b1;
                    data_oe_d = (INHIBIT_CYCLES == 1);
                    state_d   = S_INHIBIT;
                end
            end

            S_INHIBIT: begin
                to_cnt_d = '0;
                if (inh_cnt_q == c_inh_last) begin
                    data_oe_d = 1'b1;
                    state_d   = S_START;
                end else begin
                    clk_oe_d  = 1'b1;
                    inh_cnt_d = inh_cnt_q + INH_W'(1);
                    if (inh_cnt_q == c_inh_pre) begin
                        data_oe_d = 1'b1;
                    end
                end
            end

            // START is a single transfer cycle; the timeout window it opens
            // carries on through BITS until the first device edge.
            S_START: begin
                if (timeout) begin
                    data_oe_d = 1'b0;
                    err_d     = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = S_IDLE;
                end else begin
                    bit_cnt_d = '0;
                    state_d   = S_BITS;
                end
            end

            S_BITS: begin
                if (fall) begin
                    data_oe_d = ~frame_q[bit_cnt_q];
                    if (bit_cnt_q == c_bit_stop) begin
                        state_d = S_ACK;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end else if (timeout) begin
                    data_oe_d = 1'b0;
                    err_d     = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = S_IDLE;
                end
            end

            S_ACK: begin
                if (fall) begin
                    if (!dat_sync_q[1]) begin
                        state_d = S_WAIT_IDLE;
                    end else begin
                        err_d   = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end
                end else if (timeout) begin
                    data_oe_d = 1'b0;
                    err_d     = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = S_IDLE;
                end
            end

            S_WAIT_IDLE: begin
                if (filt_q && dat_sync_q[1]) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (timeout) begin
                    data_oe_d = 1'b0;
                    err_d     = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = S_IDLE;
                end
            end

            default: begin
                data_oe_d = 1'b0;
                busy_d    = 1'b0;
                state_d   = S_IDLE;
            end
        endcase
    end

    assign o_ps2_clk_oe  = clk_oe_q;
    assign o_ps2_data_oe = data_oe_q;
    assign o_busy        = busy_q;
    assign o_done        = done_q;
    assign o_err         = err_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_tx
// Brief    : Self-checking bench for ps2_tx with a behavioural PS/2 device.
// Revision : 1.0  initial release
// ============================================================================
module tb_ps2_tx;

    localparam int INH = 20;
    localparam int TMO = 200;
    localparam int FLT = 4;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic       start    = 1'b0;
    logic [7:0] data     = 8'h00;
    logic       dev_clk  = 1'b1;
    logic       dev_data = 1'b1;
    logic       ps2_clk;
    logic       ps2_data;
    logic       clk_oe;
    logic       data_oe;
    logic       busy;
    logic       done;
    logic       err;

    int n_chk    = 0;
    int n_pass   = 0;
    int done_cnt = 0;
    int err_cnt  = 0;

    // Open-drain bus: either side can pull a line low.
    assign ps2_clk  = dev_clk & ~clk_oe;
    assign ps2_data = dev_data & ~data_oe;

    always #5 clk = ~clk;

    ps2_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TMO),
        .FILTER        (FLT)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_ps2_clk    (ps2_clk),
        .i_ps2_data   (ps2_data),
        .i_start      (start),
        .i_data       (data),
        .o_ps2_clk_oe (clk_oe),
        .o_ps2_data_oe(data_oe),
        .o_busy       (busy),
        .o_done       (done),
        .o_err        (err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Line image of a frame: start, data LSB first, odd parity, stop.
    function automatic logic [10:0] ref_frame(input logic [7:0] d);
        int ones;
        logic par;
        ones = $countones(d);
        par  = ((ones % 2) == 0) ? 1'b1 : 1'b0;
        return {1'b1, par, d, 1'b0};
    endfunction

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (err)  err_cnt++;
        if (done || err) begin
            chk("pulse_exclusive", 32'(done & err), 32'd0);
            chk("busy_at_pulse", 32'(busy), 32'd0);
        end
    end

    // Device: clocks 11 falling edges, samples host data on each rising edge.
    task automatic device(input int half, input bit ack, input bit glitch,
                          input int rst_at, input bit inject,
                          output logic [10:0] bits, output bit ok);
        int w;
        w    = 0;
        bits = '0;
        ok   = 1'b1;
        while (!(!clk_oe && data_oe) && w < 500) begin
            @(negedge clk);
            w++;
        end
        if (w >= 500) begin
            chk("release_wait", 32'(w), 32'd0);
            ok = 1'b0;
            return;
        end
        repeat (half) @(negedge clk);
        bits[0] = ps2_data;
        for (int k = 1; k <= 11; k++) begin
            if (k == 11) dev_data = ~ack;
            dev_clk = 1'b0;
            repeat (half) @(negedge clk);
            if (k == rst_at) begin
                chk("pre_rst_data_oe", 32'(data_oe), 32'd1);
                #2 rst = 1'b1;
                #1;
                chk("rst_clk_oe", 32'(clk_oe), 32'd0);
                chk("rst_data_oe", 32'(data_oe), 32'd0);
                chk("rst_busy", 32'(busy), 32'd0);
                dev_clk  = 1'b1;
                dev_data = 1'b1;
                repeat (5) @(negedge clk);
                rst = 1'b0;
                ok  = 1'b0;
                return;
            end
            if (inject && k == 6) begin
                start = 1'b1;
                data  = 8'hFF;
                @(negedge clk);
                start = 1'b0;
            end
            dev_clk = 1'b1;
            if (k <= 10) bits[k] = ps2_data;
            if (k == 11) dev_data = 1'b1;
            if (glitch && k < 11) begin
                repeat (half / 2) @(negedge clk);
                dev_clk = 1'b0;
                @(negedge clk);
                dev_clk = 1'b1;
                repeat (half - half / 2 - 1) @(negedge clk);
            end else begin
                repeat (half) @(negedge clk);
            end
        end
    endtask

    task automatic send(input logic [7:0] d, input bit ack, input bit glitch,
                        input bit inject, input string tag);
        logic [10:0] bits;
        bit          ok;
        int          d0, e0, w, half;
        d0   = done_cnt;
        e0   = err_cnt;
        half = $urandom_range(12, 30);
        @(negedge clk);
        data  = d;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        data  = 8'($urandom);
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        device(half, ack, glitch, 0, inject, bits, ok);
        w = 0;
        while (done_cnt == d0 && err_cnt == e0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        repeat (3) @(negedge clk);
        chk({tag, "_bits"}, 32'(bits), 32'(ref_frame(d)));
        chk({tag, "_done"}, 32'(done_cnt - d0), ack ? 32'd1 : 32'd0);
        chk({tag, "_err"}, 32'(err_cnt - e0), ack ? 32'd0 : 32'd1);
        chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
        chk({tag, "_lines"}, {30'd0, clk_oe, data_oe}, 32'd0);
    endtask

    initial begin
        logic [10:0] bits;
        bit          ok;
        int          n_inh, n_dat, n, d0, e0;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_clk_oe", 32'(clk_oe), 32'd0);
        chk("reset_data_oe", 32'(data_oe), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_pulses", {30'd0, done, err}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        send(8'hED, 1'b1, 1'b0, 1'b0, "xED");
        send(8'h00, 1'b1, 1'b0, 1'b0, "x00");
        send(8'h01, 1'b1, 1'b0, 1'b0, "x01");
        send(8'hA5, 1'b1, 1'b0, 1'b1, "inject");
        send(8'h3C, 1'b0, 1'b0, 1'b0, "noack");

        // Device never clocks: inhibit length, then timeout latency.
        d0 = done_cnt;
        e0 = err_cnt;
        @(negedge clk);
        data  = 8'h5A;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_inh = 0;
        n_dat = 0;
        while (clk_oe && n_inh < 1000) begin
            if (data_oe) n_dat++;
            n_inh++;
            @(negedge clk);
        end
        chk("inhibit_len", 32'(n_inh), 32'(INH));
        chk("inhibit_start_bit", 32'(n_dat), 32'd1);
        chk("start_data_oe", 32'(data_oe), 32'd1);
        n = 0;
        while (!err && n < TMO + 50) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_latency", 32'(n), 32'(TMO));
        @(negedge clk);
        chk("timeout_lines", {30'd0, clk_oe, data_oe}, 32'd0);
        chk("timeout_busy", 32'(busy), 32'd0);
        chk("timeout_no_done", 32'(done_cnt - d0), 32'd0);
        chk("timeout_err", 32'(err_cnt - e0), 32'd1);

        // Reset while bit 4 (a zero) is on the line.
        d0 = done_cnt;
        e0 = err_cnt;
        @(negedge clk);
        data  = 8'h00;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        device(20, 1'b1, 1'b0, 5, 1'b0, bits, ok);
        repeat (30) @(negedge clk);
        chk("rst_no_done", 32'(done_cnt - d0), 32'd0);
        chk("rst_no_err", 32'(err_cnt - e0), 32'd0);
        send(8'hF4, 1'b1, 1'b1, 1'b0, "xF4");

        for (int i = 0; i < 8; i++) begin
            send(8'($urandom), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 1) == 1), 1'b0, "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
